wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
Multi-precision add sequencer that sits directly upstream of BrentKung16bit and feeds it.
- Accepts wide operands and a carry-in over a valid/ready handshake.
- Feeds BrentKung16bit one 16-bit word per cycle, least-significant word first, chaining each word's Cout into the next word's Cin.
- Collects the words into a wide sum and presents sum plus final carry-out over a valid/ready handshake.

Parameters:
- WORDS, 4, number of 16-bit words per operand (operand width = 16*WORDS); legal range 1..16.
- W, 16, word width; fixed to the BrentKung16bit width and not overridable in practice.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- a  input  W*WORDS  operand A.
- b  input  W*WORDS  operand B.
- cin  input  1  carry into word 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W*WORDS  a + b + cin, modulo 2^(W*WORDS).
- cout  output  1  carry out of the most-significant word.
- ovf  output  1  signed overflow: operand MSBs equal and sum MSB differs.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Word counter, carry register and operand shift registers are all cleared.
  - Reset mid-operation aborts silently; no result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a and b into shift registers, carry_r=cin, capture the MSBs of a and b for ovf, cnt=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the BrentKung16bit instance gets a=a_sh[W-1:0], b=b_sh[W-1:0], Cin=carry_r.
  - On the edge: the adder's Sum is shifted into the top of the sum register (the register shifts right by W), carry_r is set to the adder's Cout, a_sh and b_sh shift right by W, and cnt increments.
  - When cnt==WORDS-1 on the edge, go to DONE.
  - Exactly WORDS cycles are spent in RUN.
- DONE:
  - out_valid=1; sum, cout=carry_r and ovf are stable.
  - All three outputs hold unchanged while out_ready=0, for an unbounded stall.
  - On out_valid&&out_ready: go to IDLE. out_valid falls and in_ready rises on the next cycle.
- Latency: an operand accepted at edge T gives out_valid=1 from cycle T+WORDS+1.
- Throughput: one operation per WORDS+2 cycles when out_ready is held at 1. No overlap of operations.
- Boundary rules:
  - in_valid is ignored outside IDLE; inputs are sampled only on the accept edge.
  - sum, cout and ovf hold their last value after the handshake until the next DONE. Consumers use them only when out_valid=1.
  - WORDS=1: RUN lasts 1 cycle; the result equals a single BrentKung16bit add.
  - The sum wraps modulo 2^(W*WORDS); the dropped carry appears only on cout.
- The adder is combinational inside RUN. The timing path is carry_r -> adder -> carry_r, one adder delay per cycle.

Decomposition:
- Shared package add_pkg holds:
  - the constant W=16;
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a helper function for the signed-overflow calculation.
- The sub-module is the existing BrentKung16bit, instantiated once with ports a, b, Cin, Sum, Cout.
- No new sub-module is needed.

Test Plan:
- Reset then single add, WORDS=4: a=20, b=87, cin=1 -> after 5 cycles out_valid=1, sum=108, cout=0, ovf=0.
- Carry ripple across all words: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0. Also a=64'h0000_0000_0000_FFFF, b=1, cin=0 -> sum=64'h0000_0000_0001_0000, cout=0.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
- Backpressure: out_ready=0 for 10 cycles in DONE with a=25000, b=4801 -> sum=29801 held constant. in_valid pulses during the stall are ignored (in_ready=0). Raising out_ready completes exactly one handshake, and in_ready=1 on the next cycle.
- Reset mid-RUN: rst asserted 2 cycles after accepting a=3150, b=5800, cin=1 -> out_valid never rises for that operation, sum=0, in_ready=1. A new add of 7+6+1 then yields sum=14.
- Back-to-back random: 1000 random a, b, cin with out_ready held at 1 -> each result equals the reference (a+b+cin) mod 2^64, and the accept-to-accept interval is exactly 6 cycles.

Source files
------------

// File: rtl/add_pkg.sv
// Shared constants, FSM encoding and overflow helper for the multi-precision add sequencer.
package add_pkg;

   localparam int W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Two's-complement overflow: same-signed operands producing a result of the other sign.
   function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/BrentKung16bit.sv
// 16-bit Brent-Kung parallel-prefix adder; purely combinational, no handshake.
module BrentKung16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        Cin,
   output logic [15:0] Sum,
   output logic        Cout
);

   always_comb begin
      logic [15:0] g;
      logic [15:0] p;
      logic [15:0] hs;
      hs = a ^ b;
      p  = hs;
      g  = a & b;
      g[0] = g[0] | (p[0] & Cin);
      // Up-sweep builds group terms at 1,3,7,15; down-sweep fills the remaining prefixes.
      for (int d = 0; d < 4; d++) begin
         for (int i = (2 << d) - 1; i < 16; i += (2 << d)) begin
            g[i] = g[i] | (p[i] & g[i - (1 << d)]);
            p[i] = p[i] & p[i - (1 << d)];
         end
      end
      for (int d = 2; d >= 0; d--) begin
         for (int i = (3 << d) - 1; i < 16; i += (2 << d)) begin
            g[i] = g[i] | (p[i] & g[i - (1 << d)]);
         end
      end
      Sum  = hs ^ {g[14:0], Cin};
      Cout = g[15];
   end

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial wide adder: accept, WORDS cycles through BrentKung16bit, then hold result.
// Result valid WORDS edges after accept; result held indefinitely while out_ready is low.
module wide_add_seq
   import add_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W*WORDS-1:0] a,
   input  logic [W*WORDS-1:0] b,
   input  logic               cin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W*WORDS-1:0] sum,
   output logic               cout,
   output logic               ovf
);

   localparam int N  = W * WORDS;
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            carry_q;
   logic [N-1:0]    a_sh_q;
   logic [N-1:0]    b_sh_q;
   logic [N-1:0]    acc_q;
   logic [N-1:0]    acc_d;
   logic [N-1:0]    sum_q;
   logic            msb_a_q;
   logic            msb_b_q;
   logic            cout_q;
   logic            ovf_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [W-1:0]    bk_sum;
   logic            bk_cout;
   logic            last_word;

   BrentKung16bit u_bk (
      .a    (a_sh_q[W-1:0]),
      .b    (b_sh_q[W-1:0]),
      .Cin  (carry_q),
      .Sum  (bk_sum),
      .Cout (bk_cout)
   );

   // Words are slotted by index into a private accumulator so the visible sum only changes on entry to DONE.
   always_comb begin
      acc_d = acc_q;
      acc_d[int'(cnt_q) * W +: W] = bk_sum;
   end

   assign last_word = (cnt_q == CW'(WORDS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         msb_a_q     <= 1'b0;
         msb_b_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_sh_q     <= a;
                  b_sh_q     <= b;
                  carry_q    <= cin;
                  msb_a_q    <= a[N-1];
                  msb_b_q    <= b[N-1];
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               carry_q <= bk_cout;
               a_sh_q  <= a_sh_q >> W;
               b_sh_q  <= b_sh_q >> W;
               cnt_q   <= cnt_q + CW'(1);
               if (last_word) begin
                  sum_q       <= acc_d;
                  cout_q      <= bk_cout;
                  ovf_q       <= ovf_calc(msb_a_q, msb_b_q, bk_sum[W-1]);
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized self-checking bench for wide_add_seq against a plain-arithmetic reference model.
module tb_wide_add_seq;

   localparam int WORDS = 4;
   localparam int N     = 16 * WORDS;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int acc_cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   wide_add_seq #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns {ovf, cout, sum} for x + y + c at full precision.
   function automatic logic [N+1:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
      logic [N:0] t;
      t = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
      return {(x[N-1] == y[N-1]) && (t[N-1] != x[N-1]), t};
   endfunction

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tbv, input logic tc);
      int guard;
      guard    = 0;
      a        = ta;
      b        = tbv;
      cin      = tc;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (in_ready !== 1'b1) chk("accept_timeout", N'(in_ready), N'(1));
      acc_cyc = cyc + 1;
      @(negedge clk);
      in_valid = 1'b0;
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom);
   endtask

   task automatic wait_result(output int lat);
      int guard;
      guard = 0;
      while (out_valid !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (out_valid !== 1'b1) chk("result_timeout", N'(out_valid), N'(1));
      lat = cyc - acc_cyc;
   endtask

   task automatic op_check(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tbv, input logic tc);
      logic [N+1:0] r;
      int           lat;
      r = ref_add(ta, tbv, tc);
      send(ta, tbv, tc);
      wait_result(lat);
      chk({tag, "_lat"},  N'(lat),  N'(WORDS));
      chk({tag, "_sum"},  sum,      r[N-1:0]);
      chk({tag, "_cout"}, N'(cout), N'(r[N]));
      chk({tag, "_ovf"},  N'(ovf),  N'(r[N+1]));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int           lat;
      int           prev;
      int           seen;
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  N'(in_ready),  N'(1));
      chk("rst_out_valid", N'(out_valid), N'(0));
      chk("rst_sum",       sum,           N'(0));
      chk("rst_cout",      N'(cout),      N'(0));
      chk("rst_ovf",       N'(ovf),       N'(0));
      rst = 1'b0;

      op_check("basic", N'(20), N'(87), 1'b1);
      chk("basic_108", sum, N'(108));
      op_check("ripple_all", {N{1'b1}}, '0, 1'b1);
      op_check("ripple_word", N'(64'h0000_0000_0000_FFFF), N'(1), 1'b0);
      op_check("sovf", N'(64'h7FFF_FFFF_FFFF_FFFF), N'(1), 1'b0);
      op_check("nsovf", N'(64'h8000_0000_0000_0000), N'(64'h8000_0000_0000_0000), 1'b0);

      // Backpressure: result must hold and new operands must be refused.
      @(negedge clk);
      out_ready = 1'b0;
      send(N'(25000), N'(4801), 1'b0);
      wait_result(lat);
      chk("bp_lat", N'(lat), N'(WORDS));
      for (int i = 0; i < 10; i++) begin
         chk("bp_sum_hold",  sum,           N'(29801));
         chk("bp_valid",     N'(out_valid), N'(1));
         chk("bp_in_ready",  N'(in_ready),  N'(0));
         in_valid = 1'(i % 2);
         a        = {$urandom, $urandom};
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid",    N'(out_valid), N'(0));
      chk("bp_hs_in_ready", N'(in_ready),  N'(1));
      chk("bp_sum_after",   sum,           N'(29801));
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      chk("bp_no_extra", N'(seen), N'(0));

      // Reset during RUN aborts the operation.
      send(N'(3150), N'(5800), 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid",    N'(out_valid), N'(0));
      chk("abort_sum",      sum,           N'(0));
      chk("abort_in_ready", N'(in_ready),  N'(1));
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      chk("abort_no_valid", N'(seen), N'(0));
      op_check("post_abort", N'(7), N'(6), 1'b1);
      chk("post_abort_14", sum, N'(14));

      // Back-to-back random operations with the consumer always ready.
      prev = 0;
      for (int i = 0; i < 1000; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (i % 50 == 0) rb = ~ra;
         op_check("rand", ra, rb, 1'($urandom));
         if (i > 0) chk("rand_interval", N'(acc_cyc - prev), N'(WORDS + 2));
         prev = acc_cyc;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
